control_fsm: RTL

Multi-cycle control unit that drives the RV32I-subset datapath: it latches the fetched instruction, decodes it, and sequences the datapath's control inputs (RegRW, ALUsrc, ALUop, c_in, MRW, WB, PCsrc, imm_sel) across FETCH/DECODE/EXEC/MEM/WBACK states. It consumes the datapath's Instr and status outputs and adds a PC enable, so each instruction completes in 3–5 cycles with single-cycle write strobes. It also halts on unsupported encodings and counts retired instructions.

---
 rtl/control_fsm.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the RV32I-subset datapath. It latches the instruction, decodes it,
// sequences the datapath controls, halts on unsupported encodings and counts retired instructions.
//
// state  | meaning
// FETCH  | capture Instr into ir, all outputs 0
// DECODE | classify ir, controls become valid
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | RAM access; SW writes and retires here
// WBACK  | register write and retire (R/I/LW)
// HALT   | unsupported encoding, absorbing until reset
module control_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      Instr,
   input  logic [3:0]       status,
   output logic             RegRW,
   output logic             ALUsrc,
   output logic [3:0]       ALUop,
   output logic             c_in,
   output logic             MRW,
   output logic             WB,
   output logic             PCsrc,
   output logic [1:0]       imm_sel,
   output logic             pc_en,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WBACK, S_HALT
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [2:0] funct3;
   logic       is_r, is_i, is_lw, is_sw, is_br, br_ok, is_legal;
   logic       unused_bits;

   assign funct3   = ir_q[14:12];
   assign is_r     = (ir_q[6:0] == 7'b0110011);
   assign is_i     = (ir_q[6:0] == 7'b0010011);
   assign is_lw    = (ir_q[6:0] == 7'b0000011);
   assign is_sw    = (ir_q[6:0] == 7'b0100011);
   assign is_br    = (ir_q[6:0] == 7'b1100011);
   assign br_ok    = is_br && (funct3[2:1] == 2'b00);
   assign is_legal = is_r || is_i || is_lw || is_sw || is_br;

   assign unused_bits = ^{status[3:1], ir_q[31], ir_q[29:15], ir_q[11:7]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      retired_d = retired_q + CNT_W'(pc_en);
      case (state_q)
         S_FETCH: begin
            ir_d    = Instr;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_legal) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            if (is_r || is_i) begin
               state_d = S_WBACK;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else if (br_ok) begin
               state_d = S_FETCH;
            end else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_MEM:   state_d = is_lw ? S_WBACK : S_FETCH;
         S_WBACK: state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   // Controls are driven from ir only while an instruction is in flight; FETCH and HALT read 0.
   always_comb begin
      RegRW   = 1'b0;
      ALUsrc  = 1'b0;
      ALUop   = 4'b0000;
      c_in    = 1'b0;
      MRW     = 1'b0;
      WB      = 1'b0;
      PCsrc   = 1'b0;
      imm_sel = 2'b00;
      pc_en   = 1'b0;
      if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WBACK) begin
         if (is_r) begin
            ALUop = {ir_q[30], funct3};
            WB    = 1'b1;
         end else if (is_i) begin
            ALUsrc = 1'b1;
            ALUop  = {(funct3 == 3'b101) && ir_q[30], funct3};
            WB     = 1'b1;
         end else if (is_lw || is_sw) begin
            ALUsrc  = 1'b1;
            imm_sel = is_sw ? 2'b01 : 2'b00;
         end else if (is_br) begin
            ALUop   = 4'b1000;
            imm_sel = 2'b10;
         end
         c_in = ALUop[3];
      end
      RegRW = (state_q == S_WBACK);
      MRW   = (state_q == S_MEM) && is_sw;
      pc_en = (state_q == S_WBACK) || ((state_q == S_MEM) && is_sw) || ((state_q == S_EXEC) && br_ok);
      PCsrc = (state_q == S_EXEC) && br_ok && (funct3[0] ? !status[0] : status[0]);
   end

   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule
